// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, the iteration count and the Booth digit selects.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One Booth iteration per bit pair of the (WIDTH+2)-bit extended multiplier.
  function automatic int iter_of(input int width);
    return width / 2 + 1;
  endfunction

  typedef struct packed {
    logic neg;   // subtract the partial product
    logic dbl;   // partial product is 2*A
    logic zero;  // no partial product this iteration
  } booth_sel_t;

  localparam booth_sel_t ZERO = '{neg: 1'b0, dbl: 1'b0, zero: 1'b1};
  localparam booth_sel_t POS1 = '{neg: 1'b0, dbl: 1'b0, zero: 1'b0};
  localparam booth_sel_t POS2 = '{neg: 1'b0, dbl: 1'b1, zero: 1'b0};
  localparam booth_sel_t NEG1 = '{neg: 1'b1, dbl: 1'b0, zero: 1'b0};
  localparam booth_sel_t NEG2 = '{neg: 1'b1, dbl: 1'b1, zero: 1'b0};

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand-issue and result handshake bundle for booth_mul_seq.
// The master is the issuing stage and result consumer; the slave is the multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] res;
  logic               busy;

  modport master (
    output in_valid, in_signed, opa, opb, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, in_signed, opa, opb, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a {neg, dbl, zero} partial-product select.
module booth_r4_enc
  import booth_mul_pkg::*;
(
  input  logic [2:0] win_i,
  output booth_sel_t sel_o
);

  always_comb begin
    // NOTE: sel_o gets a value before the case so every path assigns it and no latch is inferred.
    sel_o = ZERO;
    case (win_i)
      3'b001, 3'b010: sel_o = POS1;
      3'b011:         sel_o = POS2;
      3'b100:         sel_o = NEG2;
      3'b101, 3'b110: sel_o = NEG1;
      default:        sel_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
// per operation, one Booth digit per cycle, one operation in flight.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  booth_mul_seq_if.slave bus
);

  localparam int ITER  = iter_of(WIDTH);
  localparam int CNT_W = $clog2(ITER);
  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   a_sh_q;
  logic [EXT_W:0]     b_sh_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   addend;
  logic [2*WIDTH-1:0] res_q;
  logic [EXT_W-1:0]   ext_a, ext_b;
  booth_sel_t         sel;
  logic               accept;
  logic               last;

  assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res       = res_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (state_q == ST_CALC) && (cnt_q == '0);

  // Two guard bits make the unsigned operand look like a positive signed one.
  assign ext_a = {{2{bus.in_signed & bus.opa[WIDTH-1]}}, bus.opa};
  assign ext_b = {{2{bus.in_signed & bus.opb[WIDTH-1]}}, bus.opb};

  // The multiplier shifts right two bits per cycle, so the window is always b_sh_q[2:0].
  booth_r4_enc u_enc (
    .win_i (b_sh_q[2:0]),
    .sel_o (sel)
  );

  always_comb begin
    addend = '0;
    if (!sel.zero) begin
      addend = sel.dbl ? {a_sh_q[ACC_W-2:0], 1'b0} : a_sh_q;
    end
    acc_d = sel.neg ? (acc_q - addend) : (acc_q + addend);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: if (last)   state_d = ST_DONE;
      ST_DONE: begin
        if (accept)             state_d = ST_CALC;
        else if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is reset as well, so res reads 0 and nothing of an aborted op survives.
    if (!rst_n) begin
      cnt_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else if (accept) begin
      cnt_q  <= CNT_W'(ITER - 1);
      a_sh_q <= {{(ACC_W - EXT_W){ext_a[EXT_W-1]}}, ext_a};
      b_sh_q <= {ext_b, 1'b0};
      acc_q  <= '0;
    end else if (state_q == ST_CALC) begin
      cnt_q  <= cnt_q - 1'b1;
      a_sh_q <= a_sh_q << 2;
      b_sh_q <= {{2{b_sh_q[EXT_W]}}, b_sh_q[EXT_W:2]};
      acc_q  <= acc_d;
      if (last) res_q <= acc_d[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases and handshake timing
// at WIDTH=16, plus randomized signed/unsigned products at WIDTH 8, 16 and 32.
module tb_booth_mul_seq;

  logic clk;
  logic rst_n;
  logic rst_aux_n;
  int   errors = 0;
  int   checks = 0;
  int   rand_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: extend each w-bit operand to 64 bits, multiply, keep the low 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] am, ae, be;
    am = (64'd1 << w) - 64'd1;
    ae = a & am;
    be = b & am;
    if (s && ae[w-1]) ae = ae | ~am;
    if (s && be[w-1]) be = be | ~am;
    return (ae * be) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // ---------------- directed instance, WIDTH=16 ----------------
  booth_mul_seq_if #(.WIDTH(16)) ifd ();
  booth_mul_seq #(.WIDTH(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifd));

  // Issue one op from a negedge; checks accept-to-out_valid latency and the product.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    int n;
    ifd.in_signed = s; ifd.opa = a; ifd.opb = b;
    ifd.in_valid = 1'b1; ifd.out_ready = 1'b1;
    #1;
    n = 0;
    while (!ifd.in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    ifd.in_valid = 1'b0;
    ifd.opa = 16'hA5A5; ifd.opb = 16'h5A5A;
    n = 0;
    while (!ifd.out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 64'(n), 64'd9);
    check(tag, 64'(ifd.res), 64'(exp));
    @(negedge clk);
  endtask

  // ---------------- randomized instances, WIDTH 8/16/32 ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 32;
    booth_mul_seq_if #(.WIDTH(W)) rif ();
    booth_mul_seq #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_aux_n), .bus(rif));

    initial begin
      logic [W-1:0] a, b;
      logic         s;
      logic [63:0]  exp;
      int           n;
      rif.in_valid = 1'b0; rif.out_ready = 1'b0; rif.in_signed = 1'b0;
      rif.opa = '0; rif.opb = '0;
      wait (rst_aux_n);
      @(negedge clk);
      for (int k = 0; k < 400; k++) begin
        s = (k >= 200);
        a = W'($urandom);
        b = W'($urandom);
        if (k % 50 == 0) a = {W{1'b1}};
        if (k % 50 == 1) begin a = {1'b1, {(W-1){1'b0}}}; b = a; end
        exp = ref_mul(W, s, 64'(a), 64'(b));
        rif.in_signed = s; rif.opa = a; rif.opb = b; rif.in_valid = 1'b1;
        #1;
        n = 0;
        while (!rif.in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        rif.in_valid = 1'b0;
        rif.opa = W'($urandom); rif.opb = W'($urandom); rif.in_signed = ~s;
        n = 0;
        while (!rif.out_valid && n < 100) begin @(negedge clk); n++; end
        check($sformatf("w%0d_lat", W), 64'(n), 64'(W / 2 + 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check($sformatf("w%0d_%s_%0h_%0h", W, s ? "s" : "u", a, b), 64'(rif.res), exp);
        rif.out_ready = 1'b1;
        @(negedge clk);
        rif.out_ready = 1'b0;
      end
      rand_done++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] exp, exp2, held;
    logic [15:0] a, b;
    logic [31:0] q[$];
    int n, nacc, nres, last_t, seen;

    rst_n = 1'b0; rst_aux_n = 1'b0;
    ifd.in_valid = 1'b0; ifd.out_ready = 1'b0; ifd.in_signed = 1'b0;
    ifd.opa = '0; ifd.opb = '0;
    #12;
    check("rst_out_valid", 64'(ifd.out_valid), 64'd0);
    check("rst_res",       64'(ifd.res),       64'd0);
    check("rst_busy",      64'(ifd.busy),      64'd0);
    check("rst_in_ready",  64'(ifd.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1; rst_aux_n = 1'b1;
    @(negedge clk);

    // Full-scale unsigned and signed corners.
    run_op("u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("s_8000_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run_op("s_ffff_0001", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);
    run_op("u_ffff_0001", 1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF);
    run_op("s_0000_1234", 1'b1, 16'h0000, 16'h1234, 32'h00000000);
    run_op("u_0000_1234", 1'b0, 16'h0000, 16'h1234, 32'h00000000);
    run_op("s_7fff_8000", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);

    // Back-pressure in DONE, then a new accept on the handshake edge.
    exp = ref_mul(16, 1'b1, 64'h7FFF, 64'h8001);
    ifd.out_ready = 1'b0;
    ifd.in_signed = 1'b1; ifd.opa = 16'h7FFF; ifd.opb = 16'h8001; ifd.in_valid = 1'b1;
    @(negedge clk);
    ifd.in_valid = 1'b0;
    n = 0;
    while (!ifd.out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_lat", 64'(n), 64'd9);
    held = ifd.res;
    ifd.in_valid = 1'b1; ifd.opa = 16'h1111; ifd.opb = 16'h2222; ifd.in_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(ifd.out_valid), 64'd1);
      check("bp_res",       64'(ifd.res),       64'(exp));
      check("bp_in_ready",  64'(ifd.in_ready),  64'd0);
    end
    check("bp_res_held", 64'(held), 64'(exp));
    exp2 = ref_mul(16, 1'b0, 64'hBEEF, 64'h0123);
    ifd.opa = 16'hBEEF; ifd.opb = 16'h0123; ifd.out_ready = 1'b1;
    #1;
    check("bp_in_ready_hs", 64'(ifd.in_ready), 64'd1);
    @(negedge clk);
    ifd.in_valid = 1'b0;
    check("bp_ov_fall",   64'(ifd.out_valid), 64'd0);
    check("bp_busy_calc", 64'(ifd.busy),      64'd1);
    check("bp_res_keep",  64'(ifd.res),       64'(exp));
    n = 0;
    while (!ifd.out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp2_lat", 64'(n), 64'd9);
    check("bp2_res", 64'(ifd.res), 64'(exp2));
    @(negedge clk);
    check("bp2_idle_ov",  64'(ifd.out_valid), 64'd0);
    check("bp2_res_keep", 64'(ifd.res),       64'(exp2));

    // Reset while CALC has cnt==3 (five edges after accept).
    ifd.in_signed = 1'b0; ifd.opa = 16'h1234; ifd.opb = 16'h5678; ifd.in_valid = 1'b1;
    @(negedge clk);
    ifd.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ifd.out_valid), 64'd0);
    check("mid_rst_res",       64'(ifd.res),       64'd0);
    check("mid_rst_busy",      64'(ifd.busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(ifd.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifd.out_valid) seen++;
    end
    check("no_stale_result", 64'(seen), 64'd0);
    check("no_stale_res",    64'(ifd.res), 64'd0);
    run_op("after_rst", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);

    // Streaming: in_valid and out_ready held high, one result every 10 cycles.
    nacc = 0; nres = 0; last_t = -1;
    ifd.out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom);
    for (int cyc = 0; cyc < 80; cyc++) begin
      ifd.in_valid = (cyc < 60);
      ifd.in_signed = a[0]; ifd.opa = a; ifd.opb = b;
      #1;
      if (ifd.out_valid) begin
        if (q.size() > 0) check("stream_res", 64'(ifd.res), 64'(q.pop_front()));
        else              check("stream_extra", 64'(ifd.res), 64'hDEAD);
        if (last_t >= 0) check("stream_gap", 64'(cyc - last_t), 64'd10);
        last_t = cyc;
        nres++;
      end
      if (ifd.in_valid && ifd.in_ready) begin
        q.push_back(32'(ref_mul(16, a[0], 64'(a), 64'(b))));
        nacc++;
        @(posedge clk);
        #1;
        a = 16'($urandom); b = 16'($urandom);
      end
      @(negedge clk);
    end
    ifd.in_valid = 1'b0;
    check("stream_accepts", 64'(nacc), 64'd6);
    check("stream_results", 64'(nres), 64'(nacc));
    check("stream_drained", 64'(q.size()), 64'd0);

    n = 0;
    while (rand_done < 3 && n < 20000) begin @(negedge clk); n++; end
    check("rand_done", 64'(rand_done), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
